// File: rtl/axi_wstrb_beat_gen.sv
// AXI W-channel beat generator: turns a write burst command plus lane-positioned
// data into W beats with computed WSTRB/WLAST, behind a one-entry output register.
module axi_wstrb_beat_gen #(
  parameter int AXI_DWIDTH    = 64,
  parameter int AXI_STRBWIDTH = AXI_DWIDTH / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [2:0]               CMD_ADDR,
  input  logic [2:0]               CMD_SIZE,
  input  logic [7:0]               CMD_LEN,
  input  logic                     DIN_VALID,
  output logic                     DIN_READY,
  input  logic [AXI_DWIDTH-1:0]    DIN,
  output logic                     WVALID,
  input  logic                     WREADY,
  output logic [AXI_DWIDTH-1:0]    WDATA,
  output logic [AXI_STRBWIDTH-1:0] WSTRB,
  output logic                     WLAST,
  output logic                     BUSY,
  output logic                     SIZE_ERR
);

  localparam int         OFFW     = $clog2(AXI_STRBWIDTH);
  localparam logic [2:0] MAX_SIZE = 3'(OFFW);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_reg, state_next;
  logic [2:0]               size_reg;
  logic [7:0]               len_reg;
  logic [7:0]               count_reg;
  logic [OFFW-1:0]          off_reg;
  logic                     wvalid_reg;
  logic [AXI_DWIDTH-1:0]    wdata_reg;
  logic [AXI_STRBWIDTH-1:0] wstrb_reg;
  logic                     wlast_reg;
  logic                     size_err_reg;

  logic                     cmd_fire;
  logic                     din_fire;
  logic                     last_load;
  logic [OFFW:0]            n_bytes;
  logic [OFFW:0]            n_low;
  logic [OFFW-1:0]          a_off;
  logic [OFFW:0]            end_lane;
  logic [AXI_STRBWIDTH-1:0] cur_strb;
  logic                     unused_addr_bits;

  // On a 32-bit bus the top address bit has no lane to select.
  assign unused_addr_bits = ^CMD_ADDR;

  assign CMD_READY = (state_reg == IDLE) && !ARESET;
  assign DIN_READY = (state_reg == BURST) && (!wvalid_reg || WREADY);
  assign cmd_fire  = CMD_VALID && CMD_READY;
  assign din_fire  = DIN_VALID && DIN_READY;
  assign last_load = din_fire && (count_reg == len_reg);

  // Container of N bytes starting at the offset aligned down to N; the lanes
  // below the current offset are masked, which only matters on the first beat.
  assign n_bytes  = (OFFW+1)'(1) << size_reg;
  assign n_low    = n_bytes - (OFFW+1)'(1);
  assign a_off    = off_reg & ~n_low[OFFW-1:0];
  assign end_lane = {1'b0, a_off} + n_bytes;

  generate
    for (genvar gi = 0; gi < AXI_STRBWIDTH; gi++) begin : g_lane
      localparam logic [OFFW:0] LANE = (OFFW+1)'(gi);
      assign cur_strb[gi] = (LANE >= {1'b0, off_reg}) && (LANE < end_lane);
    end
  endgenerate

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_fire)  state_next = BURST;
      BURST:   if (last_load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      size_reg     <= '0;
      len_reg      <= '0;
      count_reg    <= '0;
      off_reg      <= '0;
      wvalid_reg   <= 1'b0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      wlast_reg    <= 1'b0;
      size_err_reg <= 1'b0;
    end else begin
      size_err_reg <= cmd_fire && (CMD_SIZE > MAX_SIZE);
      if (cmd_fire) begin
        size_reg  <= (CMD_SIZE > MAX_SIZE) ? MAX_SIZE : CMD_SIZE;
        len_reg   <= CMD_LEN;
        off_reg   <= CMD_ADDR[OFFW-1:0];
        count_reg <= '0;
      end
      if (din_fire) begin
        wvalid_reg <= 1'b1;
        wdata_reg  <= DIN;
        wstrb_reg  <= cur_strb;
        wlast_reg  <= last_load;
        count_reg  <= count_reg + 8'd1;
        off_reg    <= end_lane[OFFW-1:0];
      end else if (WREADY) begin
        wvalid_reg <= 1'b0;
      end
    end
  end

  assign WVALID   = wvalid_reg;
  assign WDATA    = wdata_reg;
  assign WSTRB    = wstrb_reg;
  assign WLAST    = wlast_reg;
  assign BUSY     = (state_reg == BURST) || wvalid_reg;
  assign SIZE_ERR = size_err_reg;

endmodule
